cc_deserializer: RTL
====================

Name: cc_deserializer

Overview:
Fill-path beat assembler in the cache controller; the counterpart of the line-to-beat serializer on the read-response side.
- Accepts a cache-line fill request carrying the critical-word offset.
- Receives eight 64-bit memory read-data beats, returned critical-word-first with wrap-around.
- Assembles the beats into a 512-bit line in natural word order.
- Pushes one 518-bit entry into the fill FIFO.

Parameters:
None. Widths are fixed to the fill FIFO entry format: 3-bit offset + 3 reserved bits + 512-bit line, 8 beats of 64 bits.

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
req_valid_i  input  1  fill request valid
req_offset_i  input  3  critical word index (0..7) of the request
req_ready_o  output  1  block idle and able to accept a request
rdata_i  input  64  memory read data beat
rlast_i  input  1  memory marks last beat of burst
rvalid_i  input  1  beat valid
rready_o  output  1  block accepts beat
fifo_full_i  input  1  fill FIFO full
fifo_wren_o  output  1  fill FIFO write enable
fifo_wdata_o  output  518  {offset[2:0], 3'b000, line[511:0]}
err_o  output  1  one-cycle pulse: rlast protocol violation

Behaviour:
Reset (rst_n=0 at a clk edge):
- state=IDLE, cnt=0, offset=0, line=0.
- req_ready_o=1; rready_o, fifo_wren_o and err_o all 0; fifo_wdata_o=0.
- Reset mid-burst abandons the partial line with no FIFO write. Beats still in flight after reset are ignored because rready_o=0 in IDLE.

State IDLE:
- req_ready_o=1, rready_o=0.
- req_valid_i=1: latch req_offset_i, set cnt=0, go to RECV.

State RECV:
- rready_o=1, req_ready_o=0.
- Beat accepted when rvalid_i & rready_o.
- Slot index = (cnt + offset) mod 8; 3-bit wrap-around add, carry discarded.
- Slot k occupies line[511-64k -: 64]: word 0 at [511:448], word 7 at [63:0].
- cnt increments by 1 per accepted beat. No change in cycles with rvalid_i=0.
- Accepted beat with cnt==7: go to PUSH.
- rlast check on every accepted beat:
  - Required: rlast_i=1 when cnt==7, rlast_i=0 otherwise.
  - On mismatch, err_o=1 for exactly one cycle, the cycle after the offending beat.
  - Assembly always terminates on the 8th beat, independent of rlast_i.

State PUSH:
- rready_o=0, req_ready_o=0.
- fifo_wren_o = !fifo_full_i, combinational in this state.
- fifo_wdata_o = {offset, 3'b000, line}, held stable while in PUSH.
- On the cycle fifo_wren_o=1: go to IDLE.
- While fifo_full_i=1: stay in PUSH, with no beats accepted and no data lost.

Latency and throughput:
- fifo_wren_o rises at the earliest in the cycle after the 8th beat is accepted.
- Minimum of 10 cycles per line: request, 8 beats, push.
- No overlapping of requests.

Registers and invariants:
- line, offset, cnt and state are registered.
- rready_o and req_ready_o are decoded from state only; no combinational path from rvalid_i.
- fifo_wdata_o is driven directly from registers.

Test Plan:
- Offset 0, beats 0x00..07 consecutive, rlast on beat 8, FIFO not full -> one FIFO write exactly 1 cycle after beat 8; line[511:448]=0x0, line[63:0]=0x7; wdata[517:515]=0; err_o never 1.
- Offset 5, beats A0..A7 -> word5=A0, word6=A1, word7=A2, word0=A3, word4=A7; wdata[517:515]=3'b101.
- Offset 3, rvalid_i toggled 1/0 every cycle -> same line as gap-free case; cnt holds during gaps; 8 beats consumed over 15 cycles.
- fifo_full_i=1 for 4 cycles after beat 8 -> fifo_wren_o=0 and rready_o=0 during the stall; single write when full drops; fifo_wdata_o unchanged across the stall.
- rlast_i=1 on beat 4 and 0 on beat 8 -> err_o pulses twice (cycle after beat 4, cycle after beat 8); line still written after beat 8.
- rst_n asserted after beat 3, then new request with offset 0 and 8 beats -> no write for the aborted line; new line correct; slots from the aborted burst show 0 only where not overwritten.

Source files
------------

// File: rtl/cc_deserializer_if.sv
// Fill-path deserializer bus bundle.
// Groups the fill request handshake, the memory read-data beat channel, the
// fill FIFO write port and the protocol error pulse.
//   req_valid_i / req_offset_i / req_ready_o : fill request, critical word index
//   rdata_i / rlast_i / rvalid_i / rready_o  : memory read-data beats
//   fifo_full_i / fifo_wren_o / fifo_wdata_o : fill FIFO write port (518-bit entry)
//   err_o                                    : one-cycle rlast violation pulse
// The slave modport is the deserializer; the master modport is its environment.
interface cc_deserializer_if;
    logic         req_valid_i;
    logic [2:0]   req_offset_i;
    logic         req_ready_o;
    logic [63:0]  rdata_i;
    logic         rlast_i;
    logic         rvalid_i;
    logic         rready_o;
    logic         fifo_full_i;
    logic         fifo_wren_o;
    logic [517:0] fifo_wdata_o;
    logic         err_o;

    modport slave (
        input  req_valid_i,
        input  req_offset_i,
        output req_ready_o,
        input  rdata_i,
        input  rlast_i,
        input  rvalid_i,
        output rready_o,
        input  fifo_full_i,
        output fifo_wren_o,
        output fifo_wdata_o,
        output err_o
    );

    modport master (
        output req_valid_i,
        output req_offset_i,
        input  req_ready_o,
        output rdata_i,
        output rlast_i,
        output rvalid_i,
        input  rready_o,
        output fifo_full_i,
        input  fifo_wren_o,
        input  fifo_wdata_o,
        input  err_o
    );
endinterface

// File: rtl/cc_deserializer.sv
// Cache fill beat assembler.
// Takes a fill request with its critical-word offset, receives eight 64-bit
// beats returned critical-word-first with wrap-around, places each beat into
// its natural slot of a 512-bit line and pushes {offset, 3'b000, line} into
// the fill FIFO. A beat whose rlast disagrees with its position raises a
// one-cycle err_o pulse in the following cycle; assembly still ends on the
// eighth beat.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : cc_deserializer_if.slave (request, beat, FIFO and error signals)
module cc_deserializer (
    input  logic               clk,
    input  logic               rst_n,
    cc_deserializer_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StRecv, StPush} state_e;

    state_e       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [2:0]   offset_q, offset_d;
    logic [511:0] line_q, line_d;
    logic         err_q, err_d;

    logic         beat_acc;
    logic [2:0]   slot;
    logic [8:0]   slot_lsb;

    // Wrap-around slot: carry out of the 3-bit add is dropped on purpose.
    assign slot     = cnt_q + offset_q;
    // Word 0 sits at the top of the line, so slot k starts at bit 64*(7-k).
    assign slot_lsb = {3'd7 - slot, 6'd0};

    // Handshake readies decode from state only.
    assign bus.req_ready_o  = (state_q == StIdle);
    assign bus.rready_o     = (state_q == StRecv);
    assign beat_acc         = bus.rvalid_i && (state_q == StRecv);
    assign bus.fifo_wdata_o = {offset_q, 3'b000, line_q};
    assign bus.err_o        = err_q;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        offset_d        = offset_q;
        line_d          = line_q;
        err_d           = 1'b0;
        bus.fifo_wren_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid_i) begin
                    offset_d = bus.req_offset_i;
                    cnt_d    = 3'd0;
                    state_d  = StRecv;
                end
            end
            StRecv: begin
                if (beat_acc) begin
                    line_d[slot_lsb +: 64] = bus.rdata_i;
                    cnt_d                  = cnt_q + 3'd1;
                    err_d                  = bus.rlast_i != (cnt_q == 3'd7);
                    if (cnt_q == 3'd7) begin
                        state_d = StPush;
                    end
                end
            end
            StPush: begin
                bus.fifo_wren_o = !bus.fifo_full_i;
                if (!bus.fifo_full_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 3'd0;
            offset_q <= 3'd0;
            line_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            offset_q <= offset_d;
            line_q   <= line_d;
            err_q    <= err_d;
        end
    end

endmodule
